rd_req_arb: RTL and testbench
=============================

# rd_req_arb

- Fast-domain round-robin arbiter for a single read resource shared by up to N_REQ slow-domain requesters.
- Each requester's rd_en level arrives already synchronized into clk by its own sync_s2f instance.
- The block turns each rising edge into a latched pending request, grants the resource to one requester at a time, holds the grant until acknowledged, and enforces a minimum idle gap between grants.

## Interface
- N_REQ, 4, number of requesters (2..8)
- GAP, 2, idle cycles in GAP state after each completed grant (0..15)
- TIMEOUT, 16, grant abort limit in clk cycles; used only with RD_ARB_TIMEOUT_EN (1..255)
- clk  in  1  fast clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- rd_en_i  in  N_REQ  synchronized request levels; one bit per requester; high for ≥1 cycle per request
- rd_ack_i  in  1  resource completion; sampled only in GRANT
- rd_gnt_o  out  N_REQ  one-hot grant, registered
- rd_busy_o  out  1  high when state != IDLE
- rd_pend_o  out  N_REQ  pending request flags
- rd_drop_o  out  1  one-cycle pulse: request edge lost because that requester was already pending
- rd_tmo_o  out  1  one-cycle pulse: grant aborted by timeout (tied 0 without macro)

## Operation
- Edge detect: en_q <= rd_en_i; edge[i] = rd_en_i[i] & ~en_q[i]. A level held across many cycles is one request.
- Pending: edge[i] sets pend[i]. Completion of requester i's grant clears pend[i].
- Same-cycle edge and clear on the same bit: set wins; the new request stays pending.
- Edge on an already-pending bit with no same-cycle clear: request dropped, rd_drop_o pulses, pend unchanged.
- Round robin: ptr holds the last granted index. Search starts at ptr+1 and wraps modulo N_REQ. The first pending bit found wins.
- FSM:
  - IDLE: any pend set -> GRANT. rd_gnt_o <= onehot(winner); ptr <= winner.
  - GRANT: rd_ack_i=1 -> clear pend[winner], rd_gnt_o <= 0. Then GAP if GAP>0, else IDLE.
  - GAP: count GAP cycles with rd_gnt_o=0, then IDLE.
- Edges are captured in every state, including during GRANT and GAP.
- rd_ack_i outside GRANT is ignored.
- Reset values:
  - rd_gnt_o=0, rd_busy_o=0, rd_pend_o=0, rd_drop_o=0, rd_tmo_o=0.
  - en_q=0, state=IDLE, ptr=N_REQ-1, so requester 0 has first priority.
- Reset mid-GRANT: grant drops immediately (async) and all pending requests are discarded.
- If rd_en_i is high at reset release, it counts as an edge on the first clock.

## Timing
- Edge sampled at clk edge T -> pend set after T -> rd_gnt_o high after T+1. Request-to-grant latency is 2 cycles when IDLE.
- rd_ack_i sampled high at edge A -> rd_gnt_o low after A.
- Next grant:
  - GAP>0: rd_gnt_o high after A+GAP+1.
  - GAP=0: rd_gnt_o high after A+1, so there is always at least one no-grant cycle between grants.
- rd_ack_i high in the same cycle the grant first appears is accepted, giving a 1-cycle grant.
- rd_drop_o and rd_tmo_o are registered and high for exactly one cycle.

## Configuration
- RD_ARB_TIMEOUT_EN defined:
  - A counter runs while in GRANT.
  - If TIMEOUT cycles pass without rd_ack_i, the grant is removed and pend[winner] is cleared.
  - rd_tmo_o pulses, then the FSM enters GAP (or IDLE if GAP=0).
  - If rd_ack_i arrives in the timeout cycle, the ack wins and there is no pulse.
- RD_ARB_TIMEOUT_EN undefined:
  - No counter is built; the grant holds indefinitely until rd_ack_i.
  - rd_tmo_o is constant 0 and TIMEOUT is ignored.

## Test plan
- Single request, defaults: rd_en_i[2] rises at edge 10 and holds 4 cycles; ack 3 cycles after grant -> rd_gnt_o=4'b0100 after edge 11, low after ack edge; exactly one grant despite the held level.
- Round robin: rd_en_i=4'b1111 edge at reset exit; ack each grant after 1 cycle, GAP=2 -> grant order 0,1,2,3, 3 no-grant cycles between grants, rd_pend_o decrements to 0.
- Drop: requester 1 pending but not yet granted (requester 0 granted, no ack); second rd_en_i[1] edge -> rd_drop_o one pulse, single grant to 1 later.
- Set-wins: rd_en_i[0] edge in the same cycle as ack of requester 0's grant -> pend[0] stays 1, requester 0 re-granted after GAP+1.
- Reset mid-GRANT: rstn low 2 cycles while rd_gnt_o=4'b0010 and pend=4'b1010 -> all outputs 0 asynchronously; after release, the first grant goes to the lowest pending requester.
- RD_ARB_TIMEOUT_EN, TIMEOUT=16: grant with no ack -> rd_gnt_o drops after 16 cycles, rd_tmo_o pulses once, next pending requester granted after GAP+1.

Source files
------------

// File: rtl/rd_req_arb.sv
// -----------------------------------------------------------------------------
// rd_req_arb
//   Round-robin arbiter for one read resource shared by N_REQ requesters whose
//   rd_en levels are already synchronized into clk. Each rising edge of a
//   request level becomes a latched pending flag. One requester is granted at
//   a time, the grant is held until rd_ack_i, and a GAP-cycle idle window
//   follows every completed grant.
//
//   Optional feature macro: RD_ARB_TIMEOUT_EN
//     defined   : a grant held for TIMEOUT cycles without rd_ack_i is aborted,
//                 its pending flag cleared and rd_tmo_o pulses for one cycle.
//     undefined : no counter; a grant waits indefinitely, rd_tmo_o stays 0.
//
// Parameters
//   N_REQ   : number of requesters (2..8)
//   GAP     : idle cycles after each completed grant (0..15)
//   TIMEOUT : grant abort limit in cycles (1..255), RD_ARB_TIMEOUT_EN only
//
// Ports
//   clk        in   fast clock, rising edge
//   rstn       in   asynchronous active-low reset
//   rd_en_i    in   synchronized request levels, one bit per requester
//   rd_ack_i   in   resource completion, honoured only while granting
//   rd_gnt_o   out  one-hot registered grant
//   rd_busy_o  out  high whenever the FSM is not idle
//   rd_pend_o  out  pending request flags
//   rd_drop_o  out  one-cycle pulse: edge lost on an already-pending bit
//   rd_tmo_o   out  one-cycle pulse: grant aborted by timeout
// -----------------------------------------------------------------------------
module rd_req_arb #(
    parameter int N_REQ   = 4,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_REQ-1:0] rd_en_i,
    input  logic             rd_ack_i,
    output logic [N_REQ-1:0] rd_gnt_o,
    output logic             rd_busy_o,
    output logic [N_REQ-1:0] rd_pend_o,
    output logic             rd_drop_o,
    output logic             rd_tmo_o
);

    localparam int               IW      = $clog2(N_REQ);
    localparam int               GW      = 4;
    localparam logic [IW-1:0]    PTR_RST = IW'(N_REQ - 1);
    localparam logic [GW-1:0]    GAP_LD  = (GAP > 0) ? GW'(GAP - 1) : GW'(0);
    localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e           state_q;
    logic [N_REQ-1:0] en_q;
    logic [N_REQ-1:0] pend_q;
    logic [N_REQ-1:0] gnt_q;
    logic [IW-1:0]    ptr_q;
    logic [GW-1:0]    gap_q;
    logic             busy_q;
    logic             drop_q;
    logic             tmo_q;

    logic [N_REQ-1:0] edge_s;
    logic [N_REQ-1:0] clr_s;
    logic [N_REQ-1:0] pend_d;
    logic             drop_d;
    logic             done_s;
    logic             tmo_hit_s;
    logic [IW-1:0]    win_idx_s;
    logic             win_vld_s;
    logic             hit_s;

    // Index 'off' positions past 'base', wrapping modulo N_REQ.
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return IW'(sum % N_REQ);
    endfunction

`ifdef RD_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt_q;

    // An ack arriving in the final cycle takes priority over the abort.
    assign tmo_hit_s = (state_q == ST_GRANT) && !rd_ack_i && (tmo_cnt_q == TMO_LAST);

    // Cycles spent in GRANT; held at zero in every other state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_q <= 8'd0;
        end else if (state_q == ST_GRANT) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end else begin
            tmo_cnt_q <= 8'd0;
        end
    end
`else
    // No abort path: constant 0 (TIMEOUT has no effect in this build).
    assign tmo_hit_s = 1'b0 & (TIMEOUT > 0);
`endif

    // Edge detect, completion clear and pending update; a same-cycle edge
    // beats the clear so a fresh request is never lost.
    always_comb begin
        edge_s = rd_en_i & ~en_q;
        done_s = (state_q == ST_GRANT) && (rd_ack_i || tmo_hit_s);
        clr_s  = done_s ? gnt_q : {N_REQ{1'b0}};
        pend_d = (pend_q & ~clr_s) | edge_s;
        drop_d = |(edge_s & pend_q & ~clr_s);
    end

    // Round-robin search starting one past the last granted index.
    always_comb begin
        win_vld_s = 1'b0;
        win_idx_s = {IW{1'b0}};
        hit_s     = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            hit_s     = ~win_vld_s & pend_q[rr_idx(ptr_q, k)];
            win_idx_s = hit_s ? rr_idx(ptr_q, k) : win_idx_s;
            win_vld_s = win_vld_s | hit_s;
        end
    end

    // Arbitration FSM with registered grant, busy and pulse outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            en_q    <= {N_REQ{1'b0}};
            pend_q  <= {N_REQ{1'b0}};
            gnt_q   <= {N_REQ{1'b0}};
            ptr_q   <= PTR_RST;
            gap_q   <= {GW{1'b0}};
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            en_q   <= rd_en_i;
            pend_q <= pend_d;
            drop_q <= drop_d;
            tmo_q  <= tmo_hit_s;
            case (state_q)
                ST_IDLE: begin
                    if (win_vld_s) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= ONE << win_idx_s;
                        ptr_q   <= win_idx_s;
                        busy_q  <= 1'b1;
                    end else begin
                        gnt_q  <= {N_REQ{1'b0}};
                        busy_q <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (done_s) begin
                        gnt_q <= {N_REQ{1'b0}};
                        if (GAP > 0) begin
                            state_q <= ST_GAP;
                            gap_q   <= GAP_LD;
                            busy_q  <= 1'b1;
                        end else begin
                            // Returning straight to IDLE still leaves one
                            // no-grant cycle before the next winner.
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == {GW{1'b0}}) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q  <= gap_q - GW'(1);
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= {N_REQ{1'b0}};
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_gnt_o  = gnt_q;
    assign rd_busy_o = busy_q;
    assign rd_pend_o = pend_q;
    assign rd_drop_o = drop_q;
    assign rd_tmo_o  = tmo_q;

endmodule

// File: tb/tb_rd_req_arb.sv
// -----------------------------------------------------------------------------
// tb_rd_req_arb
//   Directed bench for rd_req_arb (N_REQ=4, GAP=2, TIMEOUT=16). Stimulus pushes
//   expected grant events (value + cycle), drop pulses and timeout pulses into
//   queues; a negedge monitor pops and compares each time the DUT raises a
//   grant or pulses rd_drop_o / rd_tmo_o. Cycle N means "after posedge N".
// -----------------------------------------------------------------------------
module tb_rd_req_arb;

    logic       clk;
    logic       rstn;
    logic [3:0] rd_en_i;
    logic       rd_ack_i;
    logic [3:0] rd_gnt_o;
    logic       rd_busy_o;
    logic [3:0] rd_pend_o;
    logic       rd_drop_o;
    logic       rd_tmo_o;

    rd_req_arb #(.N_REQ(4), .GAP(2), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rd_en_i   (rd_en_i),
        .rd_ack_i  (rd_ack_i),
        .rd_gnt_o  (rd_gnt_o),
        .rd_busy_o (rd_busy_o),
        .rd_pend_o (rd_pend_o),
        .rd_drop_o (rd_drop_o),
        .rd_tmo_o  (rd_tmo_o)
    );

    typedef struct {
        logic [3:0] g;
        int         c;
    } gexp_t;

    gexp_t      exp_gnt_q[$];
    int         exp_drop_q[$];
    int         exp_tmo_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    logic [3:0] gnt_prev = 4'b0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every grant rise and every pulse against the queues.
    always @(negedge clk) begin
        gexp_t e;
        int    ec;
        if (rd_gnt_o !== 4'b0000 && gnt_prev === 4'b0000) begin
            chk("gnt_onehot", {31'd0, $onehot(rd_gnt_o)}, 32'd1);
            if (exp_gnt_q.size() == 0) begin
                chk("gnt_unexpected", {28'd0, rd_gnt_o}, 32'd0);
            end else begin
                e = exp_gnt_q.pop_front();
                chk("gnt_value", {28'd0, rd_gnt_o}, {28'd0, e.g});
                chk("gnt_cycle", cyc, e.c);
            end
        end
        gnt_prev = rd_gnt_o;
        if (rd_drop_o !== 1'b0) begin
            if (exp_drop_q.size() == 0) begin
                chk("drop_unexpected", {31'd0, rd_drop_o}, 32'd0);
            end else begin
                ec = exp_drop_q.pop_front();
                chk("drop_cycle", cyc, ec);
            end
        end
        if (rd_tmo_o !== 1'b0) begin
            if (exp_tmo_q.size() == 0) begin
                chk("tmo_unexpected", {31'd0, rd_tmo_o}, 32'd0);
            end else begin
                ec = exp_tmo_q.pop_front();
                chk("tmo_cycle", cyc, ec);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int b, r, c, s, u, v, w;
        logic [3:0] ep;

        rstn     = 1'b0;
        rd_en_i  = 4'b0000;
        rd_ack_i = 1'b0;

        // ---- reset values ----
        wait_cyc(3);
        chk("rst_gnt",  {28'd0, rd_gnt_o},  32'd0);
        chk("rst_busy", {31'd0, rd_busy_o}, 32'd0);
        chk("rst_pend", {28'd0, rd_pend_o}, 32'd0);
        chk("rst_drop", {31'd0, rd_drop_o}, 32'd0);
        chk("rst_tmo",  {31'd0, rd_tmo_o},  32'd0);
        rstn = 1'b1;
        wait_cyc(5);

        // ---- single request, held 4 cycles, ack 3 cycles into grant ----
        b = cyc;
        rd_en_i = 4'b0100;
        exp_gnt_q.push_back('{4'b0100, b + 2});
        wait_cyc(b + 1);
        chk("t1_pend", {28'd0, rd_pend_o}, 32'h4);
        chk("t1_gnt_early", {28'd0, rd_gnt_o}, 32'd0);
        wait_cyc(b + 2);
        chk("t1_busy", {31'd0, rd_busy_o}, 32'd1);
        wait_cyc(b + 4);
        rd_en_i  = 4'b0000;
        rd_ack_i = 1'b1;
        wait_cyc(b + 5);
        rd_ack_i = 1'b0;
        chk("t1_gnt_off", {28'd0, rd_gnt_o}, 32'd0);
        chk("t1_pend_clr", {28'd0, rd_pend_o}, 32'd0);
        wait_cyc(b + 6);
        chk("t1_busy_gap", {31'd0, rd_busy_o}, 32'd1);
        wait_cyc(b + 7);
        chk("t1_busy_idle", {31'd0, rd_busy_o}, 32'd0);

        // ---- round robin: all four high across reset release ----
        wait_cyc(b + 10);
        rstn    = 1'b0;
        rd_en_i = 4'b1111;
        wait_cyc(b + 12);
        rstn = 1'b1;
        r = cyc;
        exp_gnt_q.push_back('{4'b0001, r + 2});
        exp_gnt_q.push_back('{4'b0010, r + 7});
        exp_gnt_q.push_back('{4'b0100, r + 12});
        exp_gnt_q.push_back('{4'b1000, r + 17});
        wait_cyc(r + 1);
        chk("t2_pend_all", {28'd0, rd_pend_o}, 32'hF);
        for (int k = 0; k < 4; k++) begin
            wait_cyc(r + 3 + 5 * k);
            rd_ack_i = 1'b1;
            wait_cyc(r + 4 + 5 * k);
            rd_ack_i = 1'b0;
            ep = 4'b1111 << (k + 1);
            chk("t2_pend_dec", {28'd0, rd_pend_o}, {28'd0, ep});
        end
        rd_en_i = 4'b0000;

        // ---- drop: requester 1 already pending while 0 is granted ----
        c = r + 23;
        wait_cyc(c);
        rd_en_i = 4'b0011;
        exp_gnt_q.push_back('{4'b0001, c + 2});
        wait_cyc(c + 2);
        rd_en_i = 4'b0001;
        wait_cyc(c + 3);
        rd_en_i = 4'b0011;
        exp_drop_q.push_back(c + 4);
        wait_cyc(c + 4);
        chk("t3_pend", {28'd0, rd_pend_o}, 32'h3);
        wait_cyc(c + 6);
        rd_ack_i = 1'b1;
        rd_en_i  = 4'b0000;
        wait_cyc(c + 7);
        rd_ack_i = 1'b0;
        chk("t3_gnt_off", {28'd0, rd_gnt_o}, 32'd0);
        chk("t3_pend1", {28'd0, rd_pend_o}, 32'h2);
        exp_gnt_q.push_back('{4'b0010, c + 10});
        wait_cyc(c + 11);
        rd_ack_i = 1'b1;
        wait_cyc(c + 12);
        rd_ack_i = 1'b0;
        chk("t3_pend_clr", {28'd0, rd_pend_o}, 32'd0);

        // ---- set wins: new edge on 0 with ack of 0's 1-cycle grant ----
        s = c + 15;
        wait_cyc(s);
        rd_en_i = 4'b0001;
        exp_gnt_q.push_back('{4'b0001, s + 2});
        wait_cyc(s + 1);
        rd_en_i = 4'b0000;
        wait_cyc(s + 2);
        rd_en_i  = 4'b0001;
        rd_ack_i = 1'b1;
        exp_gnt_q.push_back('{4'b0001, s + 6});
        wait_cyc(s + 3);
        rd_ack_i = 1'b0;
        chk("t4_gnt_off", {28'd0, rd_gnt_o}, 32'd0);
        chk("t4_pend_kept", {28'd0, rd_pend_o}, 32'h1);
        chk("t4_no_drop", {31'd0, rd_drop_o}, 32'd0);
        wait_cyc(s + 7);
        rd_ack_i = 1'b1;
        rd_en_i  = 4'b0000;
        wait_cyc(s + 8);
        rd_ack_i = 1'b0;
        chk("t4_pend_clr", {28'd0, rd_pend_o}, 32'd0);

        // ---- reset in the middle of a grant ----
        u = s + 12;
        wait_cyc(u);
        rd_en_i = 4'b1010;
        exp_gnt_q.push_back('{4'b0010, u + 2});
        wait_cyc(u + 3);
        chk("t5_gnt_pre", {28'd0, rd_gnt_o}, 32'h2);
        chk("t5_pend_pre", {28'd0, rd_pend_o}, 32'hA);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_gnt_async",  {28'd0, rd_gnt_o},  32'd0);
        chk("t5_busy_async", {31'd0, rd_busy_o}, 32'd0);
        chk("t5_pend_async", {28'd0, rd_pend_o}, 32'd0);
        wait_cyc(u + 5);
        rstn = 1'b1;
        v = cyc;
        exp_gnt_q.push_back('{4'b0010, v + 2});
        wait_cyc(v + 1);
        chk("t5_pend_post", {28'd0, rd_pend_o}, 32'hA);
        wait_cyc(v + 3);
        rd_ack_i = 1'b1;
        wait_cyc(v + 4);
        rd_ack_i = 1'b0;
        exp_gnt_q.push_back('{4'b1000, v + 7});
        wait_cyc(v + 8);
        rd_ack_i = 1'b1;
        rd_en_i  = 4'b0000;
        wait_cyc(v + 9);
        rd_ack_i = 1'b0;
        chk("t5_pend_clr", {28'd0, rd_pend_o}, 32'd0);

        // ---- grant with no ack: timeout abort or indefinite hold ----
        w = v + 13;
        wait_cyc(w);
        rd_en_i = 4'b0011;
        exp_gnt_q.push_back('{4'b0001, w + 2});
        wait_cyc(w + 3);
        rd_en_i = 4'b0000;
`ifdef RD_ARB_TIMEOUT_EN
        exp_tmo_q.push_back(w + 18);
        exp_gnt_q.push_back('{4'b0010, w + 21});
        wait_cyc(w + 17);
        chk("t6_gnt_held", {28'd0, rd_gnt_o}, 32'h1);
        wait_cyc(w + 18);
        chk("t6_gnt_abort", {28'd0, rd_gnt_o}, 32'd0);
        chk("t6_pend_left", {28'd0, rd_pend_o}, 32'h2);
        wait_cyc(w + 22);
        rd_ack_i = 1'b1;
        wait_cyc(w + 23);
        rd_ack_i = 1'b0;
        chk("t6_pend_clr", {28'd0, rd_pend_o}, 32'd0);
`else
        wait_cyc(w + 30);
        chk("t6_gnt_held", {28'd0, rd_gnt_o}, 32'h1);
        chk("t6_busy_held", {31'd0, rd_busy_o}, 32'd1);
        rd_ack_i = 1'b1;
        wait_cyc(w + 31);
        rd_ack_i = 1'b0;
        chk("t6_gnt_off", {28'd0, rd_gnt_o}, 32'd0);
        exp_gnt_q.push_back('{4'b0010, w + 34});
        wait_cyc(w + 35);
        rd_ack_i = 1'b1;
        wait_cyc(w + 36);
        rd_ack_i = 1'b0;
        chk("t6_pend_clr", {28'd0, rd_pend_o}, 32'd0);
`endif

        wait_cyc(cyc + 6);
        chk("gnt_queue_left",  exp_gnt_q.size(),  32'd0);
        chk("drop_queue_left", exp_drop_q.size(), 32'd0);
        chk("tmo_queue_left",  exp_tmo_q.size(),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
